ifu_fetch_resp: RTL
===================

Name: ifu_fetch_resp

Overview:
- Responder end of the PC-stage fetch request (fetch_req_i / fetch_pc_i).
- Accepts one fetch address at a time and issues a single read on the instruction memory bus (AR/R valid-ready channels).
- Extracts the 32-bit instruction and holds it, with its PC, for the IF stage until consumed.
- Drives fetch_stall_o back to the PC stage. On flush, drops any in-flight or held instruction.

Parameters:
- XLEN, 64, width of PC and bus address.
- INST_LEN, 32, instruction width.
- DATA_W, 64, memory read data width; instruction selected by pc[2].
- NOP_INST, 32'h00000013, value driven on inst_o for faulted fetches.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- fetch_req_i  in  1  PC stage requests a fetch of fetch_pc_i
- fetch_pc_i  in  XLEN  fetch address
- flush_i  in  1  redirect/trap; discard current fetch
- fetch_stall_o  out  1  PC stage must hold its PC
- inst_valid_o  out  1  instruction available to IF stage
- inst_o  out  INST_LEN  fetched instruction
- inst_pc_o  out  XLEN  PC of inst_o
- inst_fault_o  out  1  fetch access/misalign fault
- if_ready_i  in  1  IF stage consumes inst when inst_valid_o & if_ready_i
- mem_ar_valid_o  out  1  read address valid
- mem_ar_ready_i  in  1  read address accepted
- mem_ar_addr_o  out  XLEN  read address, {pc[XLEN-1:3],3'b000}
- mem_r_valid_i  in  1  read data valid
- mem_r_ready_o  out  1  read data accept
- mem_r_data_i  in  DATA_W  read data
- mem_r_resp_i  in  2  0 = OKAY, nonzero = error

Behaviour:
- Reset: state IDLE. All outputs 0; latched pc, inst and drop flag cleared. Reset asserted mid-transaction aborts immediately; the bus is reset with the core.
- States: IDLE, ADDR, DATA, HOLD.
- Request accept:
  - Accepted in IDLE when fetch_req_i & ~flush_i.
  - Also accepted in HOLD when inst_valid_o & if_ready_i & fetch_req_i & ~flush_i (back-to-back).
  - On accept, latch fetch_pc_i and go to ADDR.
- ADDR: mem_ar_valid_o=1 with mem_ar_addr_o from the latched pc. Address is stable until mem_ar_ready_i; the handshake moves to DATA.
- DATA: mem_r_ready_o=1. On mem_r_valid_i:
  - inst = pc[2] ? data[63:32] : data[31:0].
  - If the drop flag is set, clear it and go to IDLE with no output.
  - Otherwise go to HOLD.
- HOLD: inst_valid_o=1; inst_o, inst_pc_o and inst_fault_o are stable. On if_ready_i, go to IDLE, or to ADDR if a new request is accepted in the same cycle.
- Latency: with ar_ready and r_valid asserted immediately, the request accepted at cycle 0 gives inst_valid_o in cycle 3.
- fetch_stall_o = (state==ADDR) | (state==DATA) | (state==HOLD & ~if_ready_i). It is 0 in IDLE.
- Flush, by state:
  - IDLE: no effect, and a same-cycle request is ignored.
  - ADDR: AR stays asserted until its handshake (no AR withdrawal); drop flag set.
  - DATA: drop flag set; the response is consumed and discarded, then IDLE.
  - HOLD: inst_valid_o deasserts next cycle, go to IDLE.
  - Flush with if_ready_i in HOLD: the instruction counts as consumed, no new request.
- While the drop flag is set, fetch_stall_o stays 1 until IDLE is reached. The post-flush PC is presented after that.
- Only one outstanding bus read at any time.

Optional Feature:
- Macro IFU_ACCESS_FAULT_EN.
- Defined:
  - A request with fetch_pc_i[1:0]!=0 skips the bus and goes directly IDLE→HOLD with inst_fault_o=1.
  - mem_r_resp_i!=0 in DATA sets inst_fault_o=1.
  - Faulted entries drive inst_o=NOP_INST.
- Undefined: inst_fault_o tied 0, mem_r_resp_i ignored, misaligned PCs fetched normally.

Test Plan:
- Req pc=0x80000004, ar_ready=1, r_data=0x1111111122222222 returned next cycle -> mem_ar_addr_o=0x80000000; inst_valid_o in cycle 3 with inst_o=0x11111111, inst_pc_o=0x80000004.
- ar_ready held 0 for 5 cycles -> mem_ar_valid_o and address stable; fetch_stall_o=1 throughout; completes after ready.
- if_ready_i=0 for 4 cycles in HOLD -> inst_o and inst_pc_o stable, stall=1; then if_ready_i=1 with req pc=0x80000008 -> direct HOLD→ADDR, new AR issued next cycle.
- flush_i in DATA, then r_valid with data 0xDEAD -> inst_valid_o never asserts; IDLE; next req pc=0x80001000 fetches correctly.
- rst asserted in DATA -> all outputs 0 asynchronously, state IDLE.
- IFU_ACCESS_FAULT_EN: req pc=0x80000002 -> no AR issued, inst_fault_o=1, inst_o=0x00000013; r_resp=2 -> inst_fault_o=1.

Source files
------------

// File: rtl/ifu_fetch_resp.sv
// Fetch responder: turns one PC-stage fetch request into a single AR/R bus read and holds the
// instruction for the IF stage. Access-fault detection is enabled by defining IFU_ACCESS_FAULT_EN.
module ifu_fetch_resp #(
    parameter int                  XLEN     = 64,
    parameter int                  INST_LEN = 32,
    parameter int                  DATA_W   = 64,
    parameter logic [INST_LEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_req_i,
    input  logic [XLEN-1:0]     fetch_pc_i,
    input  logic                flush_i,
    output logic                fetch_stall_o,
    output logic                inst_valid_o,
    output logic [INST_LEN-1:0] inst_o,
    output logic [XLEN-1:0]     inst_pc_o,
    output logic                inst_fault_o,
    input  logic                if_ready_i,
    output logic                mem_ar_valid_o,
    input  logic                mem_ar_ready_i,
    output logic [XLEN-1:0]     mem_ar_addr_o,
    input  logic                mem_r_valid_i,
    output logic                mem_r_ready_o,
    input  logic [DATA_W-1:0]   mem_r_data_i,
    input  logic [1:0]          mem_r_resp_i
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t              state_reg, state_next;
    logic [XLEN-1:0]     pc_reg, pc_next;
    logic [INST_LEN-1:0] inst_reg, inst_next;
    logic                fault_reg, fault_next;
    logic                drop_reg, drop_next;
    logic                accept;
    logic                pc_misaligned;
    logic                resp_err;
    logic [INST_LEN-1:0] rdata_sel;

`ifdef IFU_ACCESS_FAULT_EN
    assign pc_misaligned = |fetch_pc_i[1:0];
    assign resp_err      = |mem_r_resp_i;
`else
    logic unused_resp;
    assign unused_resp   = ^mem_r_resp_i;
    assign pc_misaligned = 1'b0;
    assign resp_err      = 1'b0;
`endif

    // The bus word holds two instructions; pc[2] picks the upper one.
    assign rdata_sel = pc_reg[2] ? mem_r_data_i[2*INST_LEN-1:INST_LEN] : mem_r_data_i[INST_LEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            inst_reg  <= '0;
            fault_reg <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
            fault_reg <= fault_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        fault_next = fault_reg;
        drop_next  = drop_reg;
        accept     = 1'b0;

        case (state_reg)
            IDLE: accept = fetch_req_i & ~flush_i;
            ADDR: begin
                // The address phase is never withdrawn; a flush only marks the read for discard.
                if (flush_i)
                    drop_next = 1'b1;
                if (mem_ar_ready_i)
                    state_next = DATA;
            end
            DATA: begin
                if (flush_i)
                    drop_next = 1'b1;
                if (mem_r_valid_i) begin
                    if (drop_reg | flush_i) begin
                        drop_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        inst_next  = resp_err ? NOP_INST : rdata_sel;
                        fault_next = resp_err;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                accept = if_ready_i & fetch_req_i & ~flush_i;
                if (flush_i | if_ready_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (accept) begin
            pc_next = fetch_pc_i;
            if (pc_misaligned) begin
                inst_next  = NOP_INST;
                fault_next = 1'b1;
                state_next = HOLD;
            end else begin
                fault_next = 1'b0;
                state_next = ADDR;
            end
        end
    end

    assign fetch_stall_o  = (state_reg == ADDR) | (state_reg == DATA) |
                            ((state_reg == HOLD) & ~if_ready_i);
    assign inst_valid_o   = (state_reg == HOLD);
    assign inst_o         = inst_reg;
    assign inst_pc_o      = pc_reg;
    assign inst_fault_o   = fault_reg & (state_reg == HOLD);
    assign mem_ar_valid_o = (state_reg == ADDR);
    assign mem_ar_addr_o  = {pc_reg[XLEN-1:3], 3'b000};
    assign mem_r_ready_o  = (state_reg == DATA);

endmodule
